// File: rtl/fetch_pkg.sv
// Shared constants, types and helpers for the instruction-fetch PC unit and its
// optional branch history table (enabled by FETCH_BHT_EN).
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int BHT_IDX_W   = 5;
    localparam int BHT_IDX_HI  = 6;
    localparam int BHT_IDX_LO  = 2;
    localparam int BHT_ENTRIES = 32;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t SNT = 2'd0;
    localparam bht_ctr_t WNT = 2'd1;
    localparam bht_ctr_t WT  = 2'd2;
    localparam bht_ctr_t ST  = 2'd3;

    localparam logic [XLEN-1:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } if_id_t;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
        bht_ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) begin
                nxt = ctr + 2'd1;
            end else begin
                nxt = ctr;
            end
        end else begin
            if (ctr != SNT) begin
                nxt = ctr - 2'd1;
            end else begin
                nxt = ctr;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_counter_table.sv
// 32-entry table of 2-bit saturating branch counters; combinational lookup
// returns the pre-update value when reading and writing the same entry.
module bht_counter_table
    import fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BHT_IDX_W-1:0] rd_idx_i,
    output logic                 rd_taken_o,
    input  logic                 wr_en_i,
    input  logic [BHT_IDX_W-1:0] wr_idx_i,
    input  logic                 wr_taken_i
);

    bht_ctr_t ctr_q [BHT_ENTRIES];

    // Counter storage: reset to weakly-not-taken, then train on resolved branches.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= bht_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

    assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC register, next-PC selection and IF/ID pipeline register.
// Define FETCH_BHT_EN to gate BTB hits with a 2-bit branch history table.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            ex_branch_valid,
    input  logic [XLEN-1:0] ex_branch_pc,
    input  logic            ex_branch_taken,
    input  logic            btb_tag_match,
    input  logic [XLEN-1:0] btb_target_pc,
    input  logic [XLEN-1:0] imem_inst,
    output logic [XLEN-1:0] current_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_inst,
    output logic            if_id_pred_taken,
    output logic [XLEN-1:0] if_id_pred_target,
    output logic [XLEN-1:0] mispredict_count
);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    logic [XLEN-1:0] mispredict_q, mispredict_d;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] pred_target_s;
    logic            pred_taken_s;
    logic            bht_taken_s;
    logic            unused_ex_s;

`ifdef FETCH_BHT_EN
    bht_counter_table u_bht (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (pc_q[BHT_IDX_HI:BHT_IDX_LO]),
        .rd_taken_o (bht_taken_s),
        .wr_en_i    (ex_branch_valid),
        .wr_idx_i   (ex_branch_pc[BHT_IDX_HI:BHT_IDX_LO]),
        .wr_taken_i (ex_branch_taken)
    );
    assign unused_ex_s = ^{ex_branch_pc[XLEN-1:BHT_IDX_HI+1], ex_branch_pc[BHT_IDX_LO-1:0]};
`else
    assign bht_taken_s = 1'b1;
    assign unused_ex_s = ^{ex_branch_valid, ex_branch_pc, ex_branch_taken};
`endif

    // Sequential PC+4 wraps naturally at the 32-bit boundary.
    assign pc_plus4_s    = pc_q + 32'd4;
    assign pred_taken_s  = btb_tag_match & bht_taken_s;
    assign pred_target_s = pred_taken_s ? btb_target_pc : pc_plus4_s;

    // Next-state selection: reset > redirect > stall > predicted/sequential fetch.
    always_comb begin
        pc_d         = pc_q;
        if_id_d      = if_id_q;
        mispredict_d = mispredict_q;
        if (reset) begin
            pc_d         = RESET_PC;
            if_id_d      = '0;
            mispredict_d = '0;
        end else if (redirect_valid) begin
            pc_d          = redirect_pc;
            if_id_d.valid = 1'b0;
            if (mispredict_q != CNT_MAX) begin
                mispredict_d = mispredict_q + 32'd1;
            end else begin
                mispredict_d = mispredict_q;
            end
        end else if (stall) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end else begin
            pc_d                = pred_target_s;
            if_id_d.valid       = 1'b1;
            if_id_d.pc          = pc_q;
            if_id_d.inst        = imem_inst;
            if_id_d.pred_taken  = pred_taken_s;
            if_id_d.pred_target = pred_target_s;
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        if_id_q      <= if_id_d;
        mispredict_q <= mispredict_d;
    end

    assign current_pc        = pc_q;
    assign if_id_valid       = if_id_q.valid;
    assign if_id_pc          = if_id_q.pc;
    assign if_id_inst        = if_id_q.inst;
    assign if_id_pred_taken  = if_id_q.pred_taken;
    assign if_id_pred_target = if_id_q.pred_target;
    assign mispredict_count  = mispredict_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed, table-driven bench for fetch_pc_unit (RESET_PC = 0x100), with
// hand sequences for counter saturation and, under FETCH_BHT_EN, BHT training.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        ex_branch_valid = 1'b0, ex_branch_taken = 1'b0;
    logic [31:0] ex_branch_pc = 32'd0;
    logic        btb_tag_match = 1'b0;
    logic [31:0] btb_target_pc = 32'd0, imem_inst = 32'd0;
    logic [31:0] current_pc, if_id_pc, if_id_inst, if_id_pred_target, mispredict_count;
    logic        if_id_valid, if_id_pred_taken;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ex_branch_valid(ex_branch_valid), .ex_branch_pc(ex_branch_pc),
        .ex_branch_taken(ex_branch_taken),
        .btb_tag_match(btb_tag_match), .btb_target_pc(btb_target_pc),
        .imem_inst(imem_inst), .current_pc(current_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_inst(if_id_inst),
        .if_id_pred_taken(if_id_pred_taken), .if_id_pred_target(if_id_pred_target),
        .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        rst, stl, rv;
        logic [31:0] rpc;
        logic        hit;
        logic [31:0] tgt, inst;
        logic        exv;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_ipc, e_inst;
        logic        e_pt;
        logic [31:0] e_ptg, e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, stl, rv, input logic [31:0] rpc,
                                input logic hit, input logic [31:0] tgt, inst,
                                input logic exv, input logic [31:0] e_pc,
                                input logic e_v, input logic [31:0] e_ipc, e_inst,
                                input logic e_pt, input logic [31:0] e_ptg, e_cnt);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.hit = hit; v.tgt = tgt;
        v.inst = inst; v.exv = exv; v.e_pc = e_pc; v.e_v = e_v; v.e_ipc = e_ipc;
        v.e_inst = e_inst; v.e_pt = e_pt; v.e_ptg = e_ptg; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic rst, stl, rv, input logic [31:0] rpc, input logic hit,
                       input logic [31:0] tgt, inst, input logic exv,
                       input logic [31:0] expc, input logic ext);
        @(negedge clk);
        reset = rst; stall = stl; redirect_valid = rv; redirect_pc = rpc;
        btb_tag_match = hit; btb_target_pc = tgt; imem_inst = inst;
        ex_branch_valid = exv; ex_branch_pc = expc; ex_branch_taken = ext;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = mk(1,0,0,32'h0,        0,32'h0,  32'hC0DE_0000,0, 32'h100,     0,32'h0,        32'h0,        0,32'h0,  32'd0);
        vecs[1]  = mk(0,0,0,32'h0,        0,32'h0,  32'hC0DE_0001,0, 32'h104,     1,32'h100,      32'hC0DE_0001,0,32'h104,32'd0);
        vecs[2]  = mk(0,0,0,32'h0,        0,32'h0,  32'hC0DE_0002,0, 32'h108,     1,32'h104,      32'hC0DE_0002,0,32'h108,32'd0);
        vecs[3]  = mk(0,0,0,32'h0,        1,32'h200,32'hC0DE_0003,0, 32'h200,     1,32'h108,      32'hC0DE_0003,1,32'h200,32'd0);
        vecs[4]  = mk(0,1,0,32'h0,        1,32'h500,32'hC0DE_0004,0, 32'h200,     1,32'h108,      32'hC0DE_0003,1,32'h200,32'd0);
        vecs[5]  = mk(0,1,0,32'h0,        1,32'h500,32'hC0DE_0005,0, 32'h200,     1,32'h108,      32'hC0DE_0003,1,32'h200,32'd0);
        vecs[6]  = mk(0,1,0,32'h0,        1,32'h500,32'hC0DE_0006,0, 32'h200,     1,32'h108,      32'hC0DE_0003,1,32'h200,32'd0);
        vecs[7]  = mk(0,1,1,32'h300,      0,32'h0,  32'hC0DE_0007,0, 32'h300,     0,32'h108,      32'hC0DE_0003,1,32'h200,32'd1);
        vecs[8]  = mk(0,0,0,32'h0,        0,32'h0,  32'hC0DE_0008,0, 32'h304,     1,32'h300,      32'hC0DE_0008,0,32'h304,32'd1);
        vecs[9]  = mk(0,0,1,32'hFFFF_FFFC,1,32'h40, 32'hC0DE_0009,0, 32'hFFFF_FFFC,0,32'h300,     32'hC0DE_0008,0,32'h304,32'd2);
        vecs[10] = mk(0,0,0,32'h0,        0,32'h0,  32'hC0DE_000A,0, 32'h0,       1,32'hFFFF_FFFC,32'hC0DE_000A,0,32'h0,  32'd2);
        vecs[11] = mk(0,0,0,32'h0,        1,32'h40, 32'hC0DE_000B,1, 32'h40,      1,32'h0,        32'hC0DE_000B,1,32'h40, 32'd2);
        vecs[12] = mk(1,1,1,32'h300,      0,32'h0,  32'hC0DE_000C,0, 32'h100,     0,32'h0,        32'h0,        0,32'h0,  32'd0);
        vecs[13] = mk(0,1,0,32'h0,        0,32'h0,  32'hC0DE_000D,0, 32'h100,     0,32'h0,        32'h0,        0,32'h0,  32'd0);
        vecs[14] = mk(0,0,0,32'h0,        0,32'h0,  32'hC0DE_000E,0, 32'h104,     1,32'h100,      32'hC0DE_000E,0,32'h104,32'd0);

`ifndef FETCH_BHT_EN
        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].rpc, vecs[i].hit,
                vecs[i].tgt, vecs[i].inst, vecs[i].exv, 32'h0, 1'b1);
            chk($sformatf("v%0d.current_pc", i),   current_pc,              vecs[i].e_pc);
            chk($sformatf("v%0d.if_id_valid", i),  {31'd0, if_id_valid},    {31'd0, vecs[i].e_v});
            chk($sformatf("v%0d.if_id_pc", i),     if_id_pc,                vecs[i].e_ipc);
            chk($sformatf("v%0d.if_id_inst", i),   if_id_inst,              vecs[i].e_inst);
            chk($sformatf("v%0d.pred_taken", i),   {31'd0, if_id_pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("v%0d.pred_target", i),  if_id_pred_target,       vecs[i].e_ptg);
            chk($sformatf("v%0d.mispredicts", i),  mispredict_count,        vecs[i].e_cnt);
        end
`else
        cyc(1,0,0,32'h0,0,32'h0,32'h0,0,32'h0,0);
        chk("bht.reset_pc", current_pc, 32'h100);
        // Counter for index 0x40[6:2] starts weakly not-taken; train it taken twice.
        cyc(0,0,1,32'h40,0,32'h0,32'h0,0,32'h0,0);
        cyc(0,0,0,32'h0,1,32'h80,32'h0,1,32'h40,1);
        chk("bht.lookup01_pc", current_pc, 32'h44);
        chk("bht.lookup01_pt", {31'd0, if_id_pred_taken}, 32'd0);
        cyc(0,0,1,32'h40,0,32'h0,32'h0,0,32'h0,0);
        cyc(0,0,0,32'h0,1,32'h80,32'h0,1,32'h40,1);
        chk("bht.lookup10_pc", current_pc, 32'h80);
        chk("bht.lookup10_pt", {31'd0, if_id_pred_taken}, 32'd1);
        cyc(0,0,1,32'h40,0,32'h0,32'h0,0,32'h0,0);
        cyc(0,0,0,32'h0,1,32'h80,32'h0,0,32'h0,0);
        chk("bht.lookup11_pc", current_pc, 32'h80);
        for (int k = 0; k < 4; k++) cyc(0,0,1,32'h40,0,32'h0,32'h0,1,32'h40,0);
        cyc(0,0,0,32'h0,1,32'h80,32'h0,0,32'h0,0);
        chk("bht.sat0_pc", current_pc, 32'h44);
        cyc(0,0,1,32'h40,0,32'h0,32'h0,1,32'h40,1);
        cyc(0,0,0,32'h0,1,32'h80,32'h0,0,32'h0,0);
        chk("bht.sat0_plus1_pc", current_pc, 32'h44);
        // Different index (0x44) is untouched and still weakly not-taken.
        cyc(0,0,1,32'h44,0,32'h0,32'h0,0,32'h0,0);
        cyc(0,0,0,32'h0,1,32'h80,32'h0,0,32'h0,0);
        chk("bht.other_idx_pc", current_pc, 32'h48);
        cyc(0,0,0,32'h0,0,32'h0,32'h0,0,32'h0,0);
`endif

        // Mispredict counter saturation from a preloaded near-max value.
        @(negedge clk);
        force dut.mispredict_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispredict_q;
        cyc(0,1,1,32'h20,0,32'h0,32'h0,0,32'h0,0);
        chk("sat.pc", current_pc, 32'h20);
        chk("sat.count_max", mispredict_count, 32'hFFFF_FFFF);
        chk("sat.valid", {31'd0, if_id_valid}, 32'd0);
        cyc(0,0,1,32'h24,0,32'h0,32'h0,0,32'h0,0);
        chk("sat.count_hold", mispredict_count, 32'hFFFF_FFFF);
        cyc(0,0,0,32'h0,0,32'h0,32'h1234_5678,0,32'h0,0);
        chk("sat.after_pc", current_pc, 32'h28);
        chk("sat.after_ipc", if_id_pc, 32'h24);
        cyc(1,0,0,32'h0,0,32'h0,32'h0,0,32'h0,0);
        chk("sat.reset_count", mispredict_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Port clk  input  1  clock; all state updates on rising edge.
REQ-003 Port reset  input  1  reset, synchronous, active-high.
REQ-004 Port stall  input  1  hazard hold: PC and IF/ID register keep their values.
REQ-005 Port redirect_valid  input  1  EX-stage misprediction; PC must be redirected.
REQ-006 Port redirect_pc  input  32  corrected PC from EX.
REQ-007 Port ex_branch_valid  input  1  EX resolved a conditional branch this cycle.
REQ-008 Port ex_branch_pc  input  32  PC of the resolved branch.
REQ-009 Port ex_branch_taken  input  1  resolved direction.
REQ-010 Port btb_tag_match  input  1  BTB hit for current_pc.
REQ-011 Port btb_target_pc  input  32  BTB predicted target for current_pc.
REQ-012 Port imem_inst  input  32  instruction at current_pc, valid in the same cycle.
REQ-013 Port current_pc  output  32  PC register; drives BTB lookup and IMEM address.
REQ-014 Port if_id_valid, if_id_pc, if_id_inst  output  1/32/32  IF/ID pipeline register.
REQ-015 Port if_id_pred_taken, if_id_pred_target  output  1/32  prediction carried to EX.
REQ-016 Port mispredict_count  output  32  saturating count of redirects.

Function
REQ-017 pred_taken SHALL equal btb_tag_match, further gated by the BHT when FETCH_BHT_EN is defined; pred_target SHALL be btb_target_pc when pred_taken is set, else current_pc+4.
REQ-018 The next-PC priority SHALL be reset > redirect_valid > stall > pred_taken > current_pc+4.
REQ-019 On redirect_valid, the block SHALL load redirect_pc into the PC and clear if_id_valid at the next edge, regardless of stall.
REQ-020 When stall is high and redirect_valid is low, the PC and all IF/ID outputs SHALL hold their values.
REQ-021 Otherwise the block SHALL load pred_target into the PC and capture {1, current_pc, imem_inst, pred_taken, pred_target} into IF/ID in the same edge; latency from PC to IF/ID is one cycle.
REQ-022 current_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 yields 0).
REQ-023 mispredict_count SHALL increment by 1 per cycle in which redirect_valid is high, and SHALL saturate at 32'hFFFF_FFFF.

Reset
REQ-024 On reset: PC=RESET_PC, if_id_valid=0, all other IF/ID fields=0, mispredict_count=0, and all BHT counters=2'b01.
REQ-025 Reset SHALL override stall, redirect, and BHT updates; the first fetch after reset is released SHALL be at RESET_PC.

Configuration
REQ-026 Macro FETCH_BHT_EN, when defined, SHALL instantiate a 32-entry table of 2-bit saturating counters.
- Lookup index: current_pc[6:2].
- pred_taken = btb_tag_match AND counter[1].
- Update index: ex_branch_pc[6:2]; on ex_branch_valid, increment (saturating at 3) if taken, decrement (saturating at 0) otherwise.
REQ-027 For a simultaneous read and write of the same BHT entry, the read SHALL return the pre-update value.
REQ-028 Without FETCH_BHT_EN, the block SHALL contain no BHT, pred_taken SHALL equal btb_tag_match, and the ex_branch_* inputs SHALL be ignored.

Structure
REQ-029 Shared package fetch_pkg SHALL hold XLEN=32, BHT_IDX_W=5, the index bit range [6:2], and the counter constants (SNT=0, WNT=1, WT=2, ST=3).
REQ-030 The BHT SHALL be a sub-module named bht_counter_table, instantiated only under FETCH_BHT_EN.

Verification
REQ-031 Reset with RESET_PC=32'h0000_0100, then release -> current_pc=0x100 and if_id_valid=0; the next edge gives if_id_pc=0x100, current_pc=0x104.
REQ-032 btb_tag_match=1 with btb_target_pc=0x200 at PC 0x108, BHT disabled -> next current_pc=0x200, if_id_pred_taken=1, if_id_pred_target=0x200.
REQ-033 stall=1 and redirect_valid=1 with redirect_pc=0x300 in the same cycle -> current_pc=0x300, if_id_valid=0, mispredict_count increments by 1.
REQ-034 stall=1 for 3 cycles -> current_pc and all if_id_* outputs are unchanged across the 3 cycles.
REQ-035 FETCH_BHT_EN defined; 2 taken updates at ex_branch_pc=0x40 while BTB hits 0x40 -> first lookup predicts not-taken (counter 01), lookups after the first update predict taken (counter 10 then 11); 4 not-taken updates -> counter saturates at 0.
REQ-036 PC=32'hFFFF_FFFC with no hit -> next current_pc=0; mispredict_count preloaded to all ones plus a redirect -> count remains 32'hFFFF_FFFF.
